// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the kgp_risc core: pc_control command codes, flag
// bit positions and the instruction width. The decoder imports the same constants.
package kgp_risc_pkg;

  localparam int INSTR_W = 32;

  localparam logic [3:0] PC_SEQ  = 4'b0000;
  localparam logic [3:0] PC_B    = 4'b0001;
  localparam logic [3:0] PC_BR   = 4'b0010;
  localparam logic [3:0] PC_BZ   = 4'b0011;
  localparam logic [3:0] PC_BNZ  = 4'b0100;
  localparam logic [3:0] PC_BCY  = 4'b0101;
  localparam logic [3:0] PC_BNCY = 4'b0110;
  localparam logic [3:0] PC_BS   = 4'b0111;
  localparam logic [3:0] PC_BNS  = 4'b1000;
  localparam logic [3:0] PC_BV   = 4'b1001;
  localparam logic [3:0] PC_BNV  = 4'b1010;
  localparam logic [3:0] PC_CALL = 4'b1011;
  localparam logic [3:0] PC_RET  = 4'b1100;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 3;

  // Conditional branches arrive already qualified by the decoder, so any code
  // in this range simply means "take the relative branch".
  function automatic logic is_cond_branch(input logic [3:0] code);
    return (code >= PC_BZ) && (code <= PC_BNV);
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack. Push writes top+1, pop reads top; a push
// when full overwrites the oldest slot and leaves the count saturated.
module return_addr_stack #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [31:0]              push_data_i,
  output logic [31:0]              top_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     ovf_o,
  output logic                     unf_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push, do_pop;

  assign full       = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i;
  assign do_pop     = pop_i & ~empty_o;
  assign ovf_o      = push_i & full;
  assign unf_o      = pop_i & empty_o;
  assign top_data_o = mem_q[top_q];
  assign count_o    = count_q;

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    if (do_push) begin
      top_d = top_q + 1'b1;
      if (!full) count_d = count_q + 1'b1;
    end else if (do_pop) begin
      top_d   = top_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[top_q + 1'b1] <= push_data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, flag register and CALL/RET sequencing. Executes one
// pc_control command per enabled cycle; all outputs are registered.
module pc_sequencer
  import kgp_risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [3:0]                   pc_control,
  input  logic [25:0]                  imm26,
  input  logic [31:0]                  reg_target,
  input  logic [3:0]                   flags_in,
  input  logic                         flags_we,
  output logic [31:0]                  pc,
  output logic [3:0]                   flags,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf,
  output logic                         illegal_ctl
);
  logic [31:0] pc_q, pc_d;
  logic [3:0]  flags_q;
  logic        ovf_q, unf_q, ill_q;

  logic [31:0] seq, rel;
  logic        push, pop, ill;
  logic [31:0] ras_data;
  logic        ras_empty, ras_ovf_stb, ras_unf_stb;
  logic        unused_ok;

  assign unused_ok = ^reg_target[1:0];

  assign seq = pc_q + 32'd4;
  assign rel = seq + {{4{imm26[25]}}, imm26, 2'b00};

  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    ill  = 1'b0;
    if (en) begin
      pc_d = seq;
      if (pc_control == PC_B || is_cond_branch(pc_control)) begin
        pc_d = rel;
      end else if (pc_control == PC_BR) begin
        pc_d = {reg_target[31:2], 2'b00};
      end else if (pc_control == PC_CALL) begin
        pc_d = rel;
        push = 1'b1;
      end else if (pc_control == PC_RET) begin
        pop = 1'b1;
        if (!ras_empty) pc_d = ras_data;
      end else if (pc_control != PC_SEQ) begin
        ill = 1'b1;
      end
    end
  end

  return_addr_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (seq),
    .top_data_o  (ras_data),
    .count_o     (ras_count),
    .empty_o     (ras_empty),
    .ovf_o       (ras_ovf_stb),
    .unf_o       (ras_unf_stb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      flags_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (en) begin
      pc_q <= pc_d;
      if (flags_we) flags_q <= flags_in;
      ovf_q <= ovf_q | ras_ovf_stb;
      unf_q <= unf_q | ras_unf_stb;
      ill_q <= ill_q | ill;
    end
  end

  assign pc          = pc_q;
  assign flags       = flags_q;
  assign ras_ovf     = ovf_q;
  assign ras_unf     = unf_q;
  assign illegal_ctl = ill_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then
// random commands, all checked each cycle against a queue-based model.
module tb_pc_sequencer;
  localparam logic [31:0] RESET_PC  = 32'h100;
  localparam int          RAS_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  pc_control = '0;
  logic [25:0] imm26 = '0;
  logic [31:0] reg_target = '0;
  logic [3:0]  flags_in = '0;
  logic        flags_we = 1'b0;
  logic [31:0] pc;
  logic [3:0]  flags;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic        ras_ovf, ras_unf, illegal_ctl;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  pc_sequencer #(.RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_control(pc_control), .imm26(imm26),
    .reg_target(reg_target), .flags_in(flags_in), .flags_we(flags_we),
    .pc(pc), .flags(flags), .ras_count(ras_count), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf), .illegal_ctl(illegal_ctl)
  );

  always #5 clk = ~clk;

  // Reference model: the stack is a plain queue, back = most recent push.
  logic [31:0] pc_m;
  logic [3:0]  flags_m;
  logic [31:0] exp_q[$];
  bit          ovf_m, unf_m, ill_m;

  always @(posedge clk) begin : model
    logic [31:0] seq_v, rel_v;
    int          off;
    if (rst) begin
      pc_m = RESET_PC; flags_m = 0; exp_q.delete();
      ovf_m = 0; unf_m = 0; ill_m = 0;
    end else if (en) begin
      off   = int'($signed(imm26));
      seq_v = pc_m + 32'd4;
      rel_v = seq_v + 32'(off * 4);
      if (flags_we) flags_m = flags_in;
      case (int'(pc_control))
        0: pc_m = seq_v;
        2: pc_m = reg_target & 32'hFFFF_FFFC;
        1, 3, 4, 5, 6, 7, 8, 9, 10: pc_m = rel_v;
        11: begin
          if (exp_q.size() == RAS_DEPTH) begin
            void'(exp_q.pop_front());
            ovf_m = 1;
          end
          exp_q.push_back(seq_v);
          pc_m = rel_v;
        end
        12: begin
          if (exp_q.size() > 0) pc_m = exp_q.pop_back();
          else begin pc_m = seq_v; unf_m = 1; end
        end
        default: begin pc_m = seq_v; ill_m = 1; end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("pc", pc, pc_m);
      chk("flags", 32'(flags), 32'(flags_m));
      chk("ras_count", 32'(ras_count), 32'(exp_q.size()));
      chk("ras_ovf", 32'(ras_ovf), 32'(ovf_m));
      chk("ras_unf", 32'(ras_unf), 32'(unf_m));
      chk("illegal_ctl", 32'(illegal_ctl), 32'(ill_m));
    end
  end

  task automatic step(input logic e, input logic [3:0] c, input logic [25:0] imm,
                      input logic [31:0] tgt, input logic [3:0] fi, input logic fwe,
                      input logic r);
    @(negedge clk);
    en = e; pc_control = c; imm26 = imm; reg_target = tgt;
    flags_in = fi; flags_we = fwe; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 4'd11, '0, '0, '0, 1'b1, 1'b1);
    check_en = 1;
    chk("reset_pc", pc, 32'h100);
    chk("reset_flags", 32'(flags), 0);
    chk("reset_count", 32'(ras_count), 0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 4'd0, '0, '0, '0, 1'b0, 1'b0);
      chk("seq_pc", pc, 32'h100 + 32'(4 * i));
    end

    step(1'b1, 4'd2, '0, 32'h200, '0, 1'b0, 1'b0);
    chk("br_200", pc, 32'h200);
    step(1'b1, 4'd1, 26'h3FF_FFFE, '0, '0, 1'b0, 1'b0);
    chk("b_neg", pc, 32'h1FC);
    step(1'b1, 4'd2, '0, 32'h0000_1237, '0, 1'b0, 1'b0);
    chk("br_lowbits", pc, 32'h1234);
    step(1'b1, 4'd5, 26'd4, '0, '0, 1'b0, 1'b0);
    chk("cond_taken", pc, 32'h1248);

    step(1'b1, 4'd2, '0, 32'h40, '0, 1'b0, 1'b0);
    step(1'b1, 4'd11, 26'h10, '0, '0, 1'b0, 1'b0);
    chk("call_pc", pc, 32'h84);
    chk("call_count", 32'(ras_count), 1);
    step(1'b1, 4'd12, '0, '0, '0, 1'b0, 1'b0);
    chk("ret_pc", pc, 32'h44);
    chk("ret_count", 32'(ras_count), 0);

    // Nine nested calls from pc 0 push 4..36; 4 is lost to the overflow.
    step(1'b1, 4'd2, '0, 32'h0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 4'd11, '0, '0, '0, 1'b0, 1'b0);
    chk("ovf_set", 32'(ras_ovf), 1);
    chk("ovf_count", 32'(ras_count), 8);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'd12, '0, '0, '0, 1'b0, 1'b0);
      chk("lifo_ret", pc, 32'(36 - 4 * k));
    end
    chk("unf_clear", 32'(ras_unf), 0);
    step(1'b1, 4'd12, '0, '0, '0, 1'b0, 1'b0);
    chk("unf_pc", pc, 32'd12);
    chk("unf_set", 32'(ras_unf), 1);

    step(1'b0, 4'd11, 26'h5, '0, 4'b0101, 1'b1, 1'b0);
    chk("stall_pc", pc, 32'd12);
    chk("stall_count", 32'(ras_count), 0);
    chk("stall_flags", 32'(flags), 0);
    step(1'b1, 4'd0, '0, '0, 4'b1010, 1'b1, 1'b0);
    chk("flags_write", 32'(flags), 32'b1010);
    chk("flags_pc", pc, 32'd16);

    step(1'b1, 4'd14, '0, '0, '0, 1'b0, 1'b0);
    chk("illegal_pc", pc, 32'd20);
    chk("illegal_set", 32'(illegal_ctl), 1);
    step(1'b1, 4'd11, '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 4'd12, '0, '0, '0, 1'b0, 1'b1);
    chk("rst_ret_pc", pc, 32'h100);
    chk("rst_ret_count", 32'(ras_count), 0);
    chk("rst_sticky", 32'({ras_ovf, ras_unf, illegal_ctl}), 0);

    for (int n = 0; n < 800; n++) begin
      logic [3:0]  c;
      logic [25:0] imm;
      c   = ($urandom_range(0, 99) < 3) ? 4'($urandom_range(13, 15))
                                        : 4'($urandom_range(0, 12));
      imm = 26'($urandom_range(0, 127)) - 26'd64;
      step(($urandom_range(0, 9) != 0), c, imm, $urandom,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) == 0));
    end
    step(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the architectural program counter, the condition-flag register and the CALL/RET return-address stack, and carries out the `pc_control` command issued each cycle by the instruction decoder. It sits between the decoder/ALU and instruction memory. Each enabled cycle it computes and registers the next PC. It exports the latched flags back to the decoder, which uses them to resolve conditional branches.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `RAS_DEPTH`, 8, return-address stack entries; power of two, 2..32.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset rst, synchronous, active-high.
- `en`  in  1  advance enable. 0 = hold PC, stack and flags (stall).
- `pc_control`  in  4  decoder command; encoding below.
- `imm26`  in  26  signed word offset, from instruction[25:0].
- `reg_target`  in  32  register-file read data used by BR.
- `flags_in`  in  4  {overflow, sign, carry, zero} from the ALU.
- `flags_we`  in  1  latch `flags_in` this cycle.
- `pc`  out  32  current PC; feeds instruction memory address.
- `flags`  out  4  registered flags; feed the decoder.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid stack entries.
- `ras_ovf`  out  1  sticky: a CALL was made with the stack full.
- `ras_unf`  out  1  sticky: a RET was made with the stack empty.
- `illegal_ctl`  out  1  sticky: a reserved `pc_control` code was received.

## Operation
`pc_control` encoding:
- 0000 SEQ
- 0001 B
- 0010 BR
- 0011–1010 conditional branch taken (BZ, BNZ, BCY, BNCY, BS, BNS, BV, BNV). The decoder has already qualified these with the flags.
- 1011 CALL
- 1100 RET
- 1101–1111 reserved.

Definitions:
- `seq = pc + 4`
- `rel = pc + 4 + ({{4{imm26[25]}}, imm26, 2'b00})`
- All PC arithmetic is 32-bit modulo 2^32. Wrap past 32'hFFFF_FFFC is silent.

Next-PC rules, applied when `en=1`:
- SEQ: `seq`.
- B and conditional codes: `rel`.
- BR: `{reg_target[31:2], 2'b00}`. The low bits are forced to 0.
- CALL: `rel`, and push `seq`.
- CALL with the stack full: drop the oldest entry, push `seq`, `ras_count` stays at `RAS_DEPTH`, set `ras_ovf`.
- RET with the stack non-empty: pop, and the next PC is the popped value.
- RET with the stack empty: `seq`, stack unchanged, set `ras_unf`.
- Reserved codes: `seq`, and set `illegal_ctl`.

Flags:
- When `en & flags_we`, `flags <= flags_in`.
- When `en=0`, flags hold.
- A flag write and a branch in the same cycle are legal. The branch uses the command as given. The new flags become visible on `flags` the next cycle.

Reset (rst=1, overrides `en` and everything else):
- `pc = RESET_PC`
- `flags = 0`
- `ras_count = 0`
- `ras_ovf = 0`, `ras_unf = 0`, `illegal_ctl = 0`
- Stack contents are don't-care.

## Timing
- Every output is registered. There is no combinational path from any input to any output.
- Latency is one cycle. A command sampled at edge N is reflected on `pc` and `ras_count` after edge N.
- Commands are sampled only when `en=1`. With `en=0`, all state holds and sticky bits do not change.
- Sticky bits clear only on `rst`.
- Reset arriving in the middle of a CALL/RET sequence discards the whole stack. There is no partial-pop behaviour.
- Stack implementation: circular buffer with a top pointer. Push writes `top+1`. Pop reads `top`.
  - An overflow push advances `top` and overwrites the oldest slot.
  - Pointer arithmetic wraps modulo `RAS_DEPTH`.

## Structure
- The shared package `kgp_risc_pkg` holds:
  - the `pc_control` code constants (`PC_SEQ` … `PC_RET`);
  - the flag bit indices (`FLAG_Z=0`, `FLAG_C=1`, `FLAG_S=2`, `FLAG_V=3`);
  - the instruction width constant.

  The decoder must use the same package constants.
- One sub-module, `return_addr_stack`: push/pop/data/count plus overflow/underflow strobes, parameterised by depth. The next-PC mux and the flag register stay in the top module.

## Test plan
1. Reset with `RESET_PC=32'h100`, then assert SEQ for 3 cycles → `pc` reads 0x100, 0x104, 0x108, 0x10C. `flags=0`, `ras_count=0`.
2. At pc=0x200, B with imm26=26'h3FFFFFE (-2) → pc=0x1FC. BR with reg_target=32'h0000_1237 → pc=0x1234. Code 0101 with imm26=4 at pc=0x1234 → pc=0x1248.
3. At pc=0x40, CALL imm26=0x10 → pc=0x84, ras_count=1. Then RET → pc=0x44, ras_count=0.
4. With RAS_DEPTH=8, issue 9 nested CALLs → `ras_ovf=1`, `ras_count=8`. Then 8 RETs return addresses 2–9 in LIFO order. A 9th RET → pc = prior pc+4, `ras_unf=1`.
5. With `en=0`, drive CALL and `flags_we=1` → pc, count and flags unchanged. Next cycle `en=1` with `flags_in=4'b1010` → `flags=4'b1010` one cycle later.
6. Drive code 1110 → pc+4 and `illegal_ctl=1`. Assert rst during a RET → `pc=RESET_PC`, `ras_count=0`, all sticky bits cleared.
